// File: rtl/fifo_sum_pkg.sv
// Shared helpers for the vertical window-sum engine: width derivations and
// parameter legality checks.
package fifo_sum_pkg;

    // Ceiling log2; 0 and 1 both map to 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned rem;
        res = 0;
        rem = (value > 0) ? value - 1 : 0;
        for (int i = 0; i < 32; i++) begin
            if (rem > 0) begin
                res = res + 1;
                rem = rem >> 1;
            end
        end
        return res;
    endfunction

    // Index width for a counter/pointer over n entries, never below 1 bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : clog2(n);
    endfunction

    // Full-precision width of a sum of tap_num samples of data_w bits.
    function automatic int unsigned sum_w(input int unsigned data_w,
                                          input int unsigned tap_num);
        return data_w + clog2(tap_num);
    endfunction

    function automatic bit params_ok(input int unsigned data_w,
                                     input int unsigned col_num,
                                     input int unsigned row_num,
                                     input int unsigned tap_num,
                                     input int unsigned out_w,
                                     input int unsigned sat_en);
        return (data_w >= 1) && (col_num >= 2) && (tap_num >= 2) &&
               (tap_num <= row_num) && (out_w >= data_w) && (sat_en <= 1);
    endfunction

endpackage

// File: rtl/fifo_sum_linebuf.sv
// Circular delay line: each enable returns the entry written DEPTH enables
// ago and overwrites it with the new sample at the same pointer.
module fifo_sum_linebuf
    import fifo_sum_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] wr_data,
    output logic [W-1:0] rd_data_c
);

    localparam int unsigned PTR_W = idx_w(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr;

    assign rd_data_c = mem[ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
        end
    end

    // Storage is left unreset; stale contents are masked by the row counter.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/fifo_sum_win.sv
// Streaming vertical window sum: each output adds TAP_NUM vertically adjacent
// samples of one column, with saturate or wrap narrowing to OUT_W bits.
module fifo_sum_win
    import fifo_sum_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned COL_NUM = 4,
    parameter int unsigned ROW_NUM = 5,
    parameter int unsigned TAP_NUM = 3,
    parameter int unsigned OUT_W   = 8,
    parameter int unsigned SAT_EN  = 0
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              pi_sof,
    input  logic              pi_flag,
    input  logic [DATA_W-1:0] pi_data,
    output logic              po_flag,
    output logic [OUT_W-1:0]  po_data,
    output logic              po_sat,
    output logic              po_last
);

    localparam int unsigned SUM_W = sum_w(DATA_W, TAP_NUM);
    localparam int unsigned MAX_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;
    localparam int unsigned COL_W = idx_w(COL_NUM);
    localparam int unsigned ROW_W = idx_w(ROW_NUM);
    localparam logic [MAX_W-1:0] OUT_MAX = MAX_W'({OUT_W{1'b1}});
    localparam bit SAT = (SAT_EN != 0);

    if (!params_ok(DATA_W, COL_NUM, ROW_NUM, TAP_NUM, OUT_W, SAT_EN)) begin : g_param_check
        $error("fifo_sum_win: illegal parameter combination");
    end

    logic [COL_W-1:0]  cnt_col;
    logic [ROW_W-1:0]  cnt_row;
    logic [COL_W-1:0]  cur_col_c;
    logic [ROW_W-1:0]  cur_row_c;
    logic [COL_W-1:0]  col_nxt_c;
    logic [ROW_W-1:0]  row_nxt_c;
    logic              col_wrap_c;
    logic              win_c;
    logic              last_c;
    logic [DATA_W-1:0] tap_c [TAP_NUM];
    logic [SUM_W-1:0]  sum_c;
    logic [MAX_W-1:0]  sum_ext_c;
    logic              clip_c;
    logic              sat_hit_c;

    // Position of the sample on pi_data; pi_sof pins it to row 0, col 0.
    always_comb begin
        cur_col_c  = pi_sof ? '0 : cnt_col;
        cur_row_c  = pi_sof ? '0 : cnt_row;
        col_wrap_c = (cur_col_c == COL_W'(COL_NUM - 1));
        col_nxt_c  = col_wrap_c ? '0 : cur_col_c + COL_W'(1);
        row_nxt_c  = cur_row_c;
        if (col_wrap_c) begin
            row_nxt_c = (cur_row_c == ROW_W'(ROW_NUM - 1)) ? '0 : cur_row_c + ROW_W'(1);
        end
        win_c  = pi_flag && (cur_row_c >= ROW_W'(TAP_NUM - 1));
        last_c = win_c && col_wrap_c && (cur_row_c == ROW_W'(ROW_NUM - 1));
    end

    // tap_c[k] is the sample k rows above the current one.
    assign tap_c[0] = pi_data;

    for (genvar k = 1; k < TAP_NUM; k++) begin : g_tap
        fifo_sum_linebuf #(
            .DEPTH (COL_NUM),
            .W     (DATA_W)
        ) u_linebuf (
            .clk       (sys_clk),
            .rst_n     (sys_rst_n),
            .en        (pi_flag),
            .wr_data   (tap_c[k-1]),
            .rd_data_c (tap_c[k])
        );
    end

    always_comb begin
        sum_c = '0;
        for (int j = 0; j < TAP_NUM; j++) begin
            sum_c = sum_c + SUM_W'(tap_c[j]);
        end
        sum_ext_c = MAX_W'(sum_c);
        clip_c    = (sum_ext_c > OUT_MAX);
        sat_hit_c = clip_c && SAT;
    end

    // Counters and registered outputs; po_data holds between valid sums.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_col <= '0;
            cnt_row <= '0;
            po_flag <= 1'b0;
            po_data <= '0;
            po_sat  <= 1'b0;
            po_last <= 1'b0;
        end else begin
            if (pi_flag) begin
                cnt_col <= col_nxt_c;
                cnt_row <= row_nxt_c;
            end else if (pi_sof) begin
                cnt_col <= '0;
                cnt_row <= '0;
            end
            po_flag <= win_c;
            po_sat  <= win_c && sat_hit_c;
            po_last <= last_c;
            if (win_c) begin
                po_data <= sat_hit_c ? '1 : OUT_W'(sum_ext_c);
            end
        end
    end

endmodule

// File: tb/tb_fifo_sum_win.sv
// Directed bench for fifo_sum_win: default, saturating, wide-output and
// two-tap instances share one stimulus bus.
module tb_fifo_sum_win;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       pi_sof    = 1'b0;
    logic       pi_flag   = 1'b0;
    logic [7:0] pi_data   = 8'd0;

    logic       d_flag, d_sat, d_last;
    logic [7:0] d_data;
    logic       s_flag, s_sat, s_last;
    logic [7:0] s_data;
    logic       w_flag, w_sat, w_last;
    logic [9:0] w_data;
    logic       t_flag, t_sat, t_last;
    logic [7:0] t_data;

    int n_vec = 0;
    int n_bad = 0;

    int exp_def [12] = '{12, 15, 18, 21, 24, 27, 30, 33, 36, 39, 42, 45};
    int exp_t2  [12] = '{6, 8, 10, 12, 14, 16, 18, 20, 22, 24, 26, 28};
    int exp_sof [12] = '{162, 165, 168, 171, 174, 177, 180, 183, 186, 189, 192, 195};

    always #5 sys_clk = ~sys_clk;

    fifo_sum_win u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi_sof(pi_sof), .pi_flag(pi_flag),
        .pi_data(pi_data), .po_flag(d_flag), .po_data(d_data), .po_sat(d_sat), .po_last(d_last)
    );

    fifo_sum_win #(.SAT_EN(1)) u_sat (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi_sof(pi_sof), .pi_flag(pi_flag),
        .pi_data(pi_data), .po_flag(s_flag), .po_data(s_data), .po_sat(s_sat), .po_last(s_last)
    );

    fifo_sum_win #(.OUT_W(10)) u_w10 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi_sof(pi_sof), .pi_flag(pi_flag),
        .pi_data(pi_data), .po_flag(w_flag), .po_data(w_data), .po_sat(w_sat), .po_last(w_last)
    );

    fifo_sum_win #(.TAP_NUM(2), .COL_NUM(6), .ROW_NUM(3)) u_t2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .pi_sof(pi_sof), .pi_flag(pi_flag),
        .pi_data(pi_data), .po_flag(t_flag), .po_data(t_data), .po_sat(t_sat), .po_last(t_last)
    );

    task automatic test_reset();
        sys_rst_n = 1'b0;
        pi_sof    = 1'b0;
        pi_flag   = 1'b0;
        pi_data   = 8'd0;
        repeat (2) @(negedge sys_clk);
        n_vec++;
        if ({d_flag, d_sat, d_last} !== 3'b000 || d_data !== 8'd0) begin
            n_bad++;
            $display("FAIL reset: flag/sat/last=%b%b%b data=%0d, want 000 data=0",
                     d_flag, d_sat, d_last, d_data);
        end
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    // One 20-sample frame with data 4*r+c; gapped adds idle cycles between samples.
    task automatic test_frame(input bit gapped, input string tag);
        int unsigned gap;
        for (int i = 0; i < 20; i++) begin
            pi_sof  = 1'b0;
            pi_flag = 1'b1;
            pi_data = 8'(i);
            @(negedge sys_clk);
            pi_flag = 1'b0;
            n_vec++;
            if (i >= 8) begin
                if (d_flag !== 1'b1 || d_data !== 8'(exp_def[i-8]) ||
                    d_last !== (i == 19) || d_sat !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s[%0d]: flag=%b data=%0d last=%b sat=%b, want 1 %0d %b 0",
                             tag, i, d_flag, d_data, d_last, d_sat, exp_def[i-8], (i == 19));
                end
            end else if (d_flag !== 1'b0 || d_last !== 1'b0) begin
                n_bad++;
                $display("FAIL %s[%0d]: flag=%b last=%b, want 0 0", tag, i, d_flag, d_last);
            end
            gap = !gapped ? 0 : ((i % 2 == 0) ? 2 : $urandom_range(0, 5));
            for (int g = 0; g < int'(gap); g++) begin
                @(negedge sys_clk);
                n_vec++;
                if (d_flag !== 1'b0 || d_last !== 1'b0 ||
                    (i >= 8 && d_data !== 8'(exp_def[i-8]))) begin
                    n_bad++;
                    $display("FAIL %s_gap[%0d]: flag=%b last=%b data=%0d, want 0 0 hold",
                             tag, i, d_flag, d_last, d_data);
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            pi_sof  = (i == 0);
            pi_flag = 1'b1;
            pi_data = 8'd100;
            @(negedge sys_clk);
            pi_sof  = 1'b0;
            pi_flag = 1'b0;
            n_vec++;
            if (i >= 8) begin
                if (d_flag !== 1'b1 || d_data !== 8'd44 || d_sat !== 1'b0) begin
                    n_bad++;
                    $display("FAIL wrap[%0d]: flag=%b data=%0d sat=%b, want 1 44 0",
                             i, d_flag, d_data, d_sat);
                end
                n_vec++;
                if (s_flag !== 1'b1 || s_data !== 8'd255 || s_sat !== 1'b1) begin
                    n_bad++;
                    $display("FAIL sat[%0d]: flag=%b data=%0d sat=%b, want 1 255 1",
                             i, s_flag, s_data, s_sat);
                end
                n_vec++;
                if (w_flag !== 1'b1 || w_data !== 10'd300 || w_sat !== 1'b0) begin
                    n_bad++;
                    $display("FAIL wide[%0d]: flag=%b data=%0d sat=%b, want 1 300 0",
                             i, w_flag, w_data, w_sat);
                end
            end else begin
                if (d_flag !== 1'b0 || s_flag !== 1'b0 || s_sat !== 1'b0 || w_flag !== 1'b0) begin
                    n_bad++;
                    $display("FAIL sat_idle[%0d]: flags=%b%b%b s_sat=%b, want 000 0",
                             i, d_flag, s_flag, w_flag, s_sat);
                end
            end
        end
    endtask

    task automatic test_tap2();
        for (int i = 0; i < 18; i++) begin
            pi_sof  = (i == 0);
            pi_flag = 1'b1;
            pi_data = 8'(i);
            @(negedge sys_clk);
            pi_sof  = 1'b0;
            pi_flag = 1'b0;
            n_vec++;
            if (i >= 6) begin
                if (t_flag !== 1'b1 || t_data !== 8'(exp_t2[i-6]) || t_last !== (i == 17)) begin
                    n_bad++;
                    $display("FAIL tap2[%0d]: flag=%b data=%0d last=%b, want 1 %0d %b",
                             i, t_flag, t_data, t_last, exp_t2[i-6], (i == 17));
                end
            end else if (t_flag !== 1'b0) begin
                n_bad++;
                $display("FAIL tap2[%0d]: flag=%b, want 0", i, t_flag);
            end
        end
    endtask

    // Partial frame of 6 samples, then pi_sof restarts with a fresh 20-sample frame.
    task automatic test_sof_restart();
        int n_out;
        n_out = 0;
        for (int i = 0; i < 26; i++) begin
            pi_sof  = (i == 0) || (i == 6);
            pi_flag = 1'b1;
            pi_data = (i < 6) ? 8'(200 + i) : 8'(50 + i - 6);
            @(negedge sys_clk);
            pi_sof  = 1'b0;
            pi_flag = 1'b0;
            if (d_flag === 1'b1) n_out++;
            n_vec++;
            if (i >= 14) begin
                if (d_flag !== 1'b1 || d_data !== 8'(exp_sof[i-14]) || d_last !== (i == 25)) begin
                    n_bad++;
                    $display("FAIL sof[%0d]: flag=%b data=%0d last=%b, want 1 %0d %b",
                             i, d_flag, d_data, d_last, exp_sof[i-14], (i == 25));
                end
            end else if (d_flag !== 1'b0) begin
                n_bad++;
                $display("FAIL sof[%0d]: flag=%b, want 0", i, d_flag);
            end
        end
        n_vec++;
        if (n_out != 12) begin
            n_bad++;
            $display("FAIL sof_count: outputs=%0d, want 12", n_out);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 14; i++) begin
            pi_sof  = (i == 0);
            pi_flag = 1'b1;
            pi_data = 8'(i);
            @(negedge sys_clk);
            pi_sof  = 1'b0;
            pi_flag = 1'b0;
        end
        n_vec++;
        if (d_flag !== 1'b1 || d_data !== 8'd27) begin
            n_bad++;
            $display("FAIL pre_reset: flag=%b data=%0d, want 1 27", d_flag, d_data);
        end
        sys_rst_n = 1'b0;
        #1;
        n_vec++;
        if ({d_flag, d_sat, d_last} !== 3'b000 || d_data !== 8'd0) begin
            n_bad++;
            $display("FAIL mid_reset_async: flag/sat/last=%b%b%b data=%0d, want 000 0",
                     d_flag, d_sat, d_last, d_data);
        end
        repeat (2) begin
            @(negedge sys_clk);
            n_vec++;
            if ({d_flag, d_sat, d_last} !== 3'b000 || d_data !== 8'd0) begin
                n_bad++;
                $display("FAIL mid_reset: flag/sat/last=%b%b%b data=%0d, want 000 0",
                         d_flag, d_sat, d_last, d_data);
            end
        end
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        test_frame(1'b0, "post_reset");
    endtask

    initial begin
        test_reset();
        test_frame(1'b0, "cont");
        test_frame(1'b1, "gapped");
        test_saturation();
        test_tap2();
        test_sof_restart();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_sum_win.md
Name: fifo_sum_win

Overview:
- Streaming vertical window-sum engine for row-major matrix data: each output is the sum of TAP_NUM vertically adjacent samples in the same column.
- Successor to the fixed 3-row, 8-bit column-sum controller. Generalised in data width, columns, rows, tap count and output width, with selectable saturate/wrap arithmetic and frame restart.
- Sits between the serial data source (uart_rx-style pi_flag/pi_data) and the downstream consumer.

Parameters:
- DATA_W, 8: input sample width.
- COL_NUM, 4: samples per row (>=2).
- ROW_NUM, 5: rows per frame (>=TAP_NUM).
- TAP_NUM, 3: rows summed per output (2..ROW_NUM).
- OUT_W, 8: output width (>=DATA_W).
- SAT_EN, 0: 1 = saturate sum to all-ones; 0 = keep low OUT_W bits.

Ports:
- sys_clk, input, 1: system clock. One clock domain only.
- sys_rst_n, input, 1: reset. Asynchronous assertion, active-low.
- pi_sof, input, 1: start of frame. Qualified alone or together with pi_flag.
- pi_flag, input, 1: input sample valid, single-cycle per sample. Gaps between samples are arbitrary.
- pi_data, input, DATA_W: input sample.
- po_flag, output, 1: output sum valid.
- po_data, output, OUT_W: window sum.
- po_sat, output, 1: the current po_data was clipped (SAT_EN=1 only).
- po_last, output, 1: pulses with the final sum of the frame.

Behaviour:
- Reset values: all outputs 0, counters 0. Line-buffer contents are don't-care, because they are gated by cnt_row.
- Counters:
  - cnt_col advances on pi_flag and wraps COL_NUM-1 -> 0.
  - cnt_row increments when cnt_col wraps and wraps ROW_NUM-1 -> 0.
  - No pi_sof is needed between consecutive frames.
- pi_sof:
  - pi_sof=1 forces the accepted sample (if pi_flag=1) to row 0, col 0. Counters then become col 1, row 0.
  - pi_sof without pi_flag clears both counters.
  - Mid-frame pi_sof abandons the partial frame. No output is produced until TAP_NUM-1 full new rows have been received.
- Line buffers:
  - TAP_NUM-1 chained delay lines, each COL_NUM deep, all shifting only on pi_flag.
  - Buffer k output is the sample from k rows above the current one.
- Sum: pi_data plus all TAP_NUM-1 buffer outputs, computed at full width DATA_W+clog2(TAP_NUM).
- Output timing:
  - po_flag is asserted exactly 1 cycle after a pi_flag whose cnt_row >= TAP_NUM-1. Latency is 1.
  - Outputs per frame: (ROW_NUM-TAP_NUM+1)*COL_NUM.
  - po_data holds its value when po_flag=0.
- Width rule:
  - If the full sum fits in OUT_W, it is output exactly.
  - Otherwise, with SAT_EN=1: output is 2^OUT_W-1 and po_sat=1.
  - Otherwise, with SAT_EN=0: output is the low OUT_W bits and po_sat=0.
  - po_sat is valid only with po_flag and is 0 otherwise.
- po_last: asserted with po_flag for the sample at row ROW_NUM-1, col COL_NUM-1.
- Back-to-back pi_flag every cycle must be supported: throughput is 1 sample/cycle.
- Reset mid-operation: outputs go to 0 immediately. The next frame behaves as if from power-up.

Decomposition:
- Shared package fifo_sum_pkg holds:
  - the clog2 function;
  - the SUM_W = DATA_W+clog2(TAP_NUM) derivation;
  - the parameter legality checks.
- One sub-module: fifo_sum_linebuf.
  - Circular register/RAM delay line, depth COL_NUM, width DATA_W, with an enable.
  - On the enable it reads the oldest entry and writes the new one at the same pointer.
  - Instantiated TAP_NUM-1 times through a generate loop.

Test Plan:
- Defaults, pi_data = 4*r+c, continuous pi_flag, 20 samples -> 12 outputs: 12,15,18,21 / 24,27,30,33 / 36,39,42,45. po_last with 45 only. Each output 1 cycle after its input.
- Same stimulus with pi_flag every third cycle and a random gap of 0–5 idle cycles -> identical output sequence. No output in gap cycles.
- All samples 100, TAP_NUM=3, OUT_W=8:
  - SAT_EN=0 -> 44, po_sat=0.
  - SAT_EN=1 -> 255, po_sat=1.
  - OUT_W=10 -> 300, po_sat=0.
- TAP_NUM=2, COL_NUM=6, ROW_NUM=3, data 6*r+c -> 12 outputs: 6,8,10,12,14,16 then 18,20,22,24,26,28.
- Defaults: pi_sof with sample 6 of a frame, then a full new frame -> no output until new row 2. Exactly 12 outputs, first = new r0c0 + r1c0 + r2c0.
- Assert sys_rst_n low mid-row 3 for 2 cycles -> po_flag/po_data/po_last/po_sat are 0 during reset. The next 20-sample frame gives the exact first-test sequence.
